// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl
// Per-triangle traversal sequencer for the rasterizer front end.
// A triangle (three vertices, unsigned COORD_W fixed point with FRAC_BITS
// fractional bits) is accepted over tri_valid/tri_ready. The block rounds the
// bounding box to integer pixels, clamps it to the screen and then emits every
// pixel of the box in row-major order on the pix_valid/pix_ready stream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tri_valid/tri_ready   triangle handshake
//   v0x..v2x, v0y..v2y    vertex coordinates
//   pix_valid/pix_ready   pixel stream handshake
//   pix_x, pix_y          current pixel coordinate
//   pix_last              current pixel is the last one of the box
//   busy                  sequencer is not idle
//   done                  one-cycle pulse when a triangle completes
module raster_scan_ctrl #(
    parameter int COORD_W   = 16,
    parameter int FRAC_BITS = 6,
    parameter int PIX_W     = 10,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] v0x,
    input  logic [COORD_W-1:0] v1x,
    input  logic [COORD_W-1:0] v2x,
    input  logic [COORD_W-1:0] v0y,
    input  logic [COORD_W-1:0] v1y,
    input  logic [COORD_W-1:0] v2y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_W-1:0]   pix_x,
    output logic [PIX_W-1:0]   pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);

    // Rounded intermediate keeps one extra bit so 0xFFFF rounds to 1024.
    localparam int RW = COORD_W - FRAC_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOX  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [COORD_W-1:0] v0x_r, v1x_r, v2x_r, v0y_r, v1y_r, v2y_r;
    logic [PIX_W-1:0]   xmin_r, xmax_r, ymin_r, ymax_r;
    logic [PIX_W-1:0]   pix_x_r, pix_y_r;
    logic               pix_valid_r, pix_last_r, busy_r, done_r;

    logic [RW-1:0]      rxmin_s, rxmax_s, rymin_s, rymax_s;
    logic [RW-1:0]      cxmax_s, cymax_s;
    logic [PIX_W-1:0]   bx_min_s, bx_max_s, by_min_s, by_max_s;
    logic               empty_s, single_s;
    logic [PIX_W-1:0]   nx_s, ny_s;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Round-half-up to an integer pixel; the carry lands in the extra bit.
    function automatic logic [RW-1:0] round_fx(input logic [COORD_W-1:0] v);
        logic [RW-1:0] ip;
        ip = RW'(v >> FRAC_BITS);
        return ip + RW'(v[FRAC_BITS-1]);
    endfunction

    // Bounding box of the registered vertices: round, clamp max, detect empty.
    always_comb begin
        rxmin_s = round_fx(min3(v0x_r, v1x_r, v2x_r));
        rxmax_s = round_fx(max3(v0x_r, v1x_r, v2x_r));
        rymin_s = round_fx(min3(v0y_r, v1y_r, v2y_r));
        rymax_s = round_fx(max3(v0y_r, v1y_r, v2y_r));
        if (rxmax_s > RW'(SCREEN_W - 1)) begin
            cxmax_s = RW'(SCREEN_W - 1);
        end else begin
            cxmax_s = rxmax_s;
        end
        if (rymax_s > RW'(SCREEN_H - 1)) begin
            cymax_s = RW'(SCREEN_H - 1);
        end else begin
            cymax_s = rymax_s;
        end
        empty_s  = (rxmin_s > RW'(SCREEN_W - 1)) || (rymin_s > RW'(SCREEN_H - 1));
        // Only consumed when the box is non-empty, where everything fits PIX_W.
        bx_min_s = PIX_W'(rxmin_s);
        bx_max_s = PIX_W'(cxmax_s);
        by_min_s = PIX_W'(rymin_s);
        by_max_s = PIX_W'(cymax_s);
        single_s = (bx_min_s == bx_max_s) && (by_min_s == by_max_s);
    end

    // Next raster position after the current pixel transfers.
    always_comb begin
        if (pix_x_r < xmax_r) begin
            nx_s = pix_x_r + PIX_W'(1);
            ny_s = pix_y_r;
        end else begin
            nx_s = xmin_r;
            ny_s = pix_y_r + PIX_W'(1);
        end
    end

    // Sequencer FSM with registered stream and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            v0x_r       <= '0;
            v1x_r       <= '0;
            v2x_r       <= '0;
            v0y_r       <= '0;
            v1y_r       <= '0;
            v2y_r       <= '0;
            xmin_r      <= '0;
            xmax_r      <= '0;
            ymin_r      <= '0;
            ymax_r      <= '0;
            pix_x_r     <= '0;
            pix_y_r     <= '0;
            pix_valid_r <= 1'b0;
            pix_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (tri_valid) begin
                        v0x_r   <= v0x;
                        v1x_r   <= v1x;
                        v2x_r   <= v2x;
                        v0y_r   <= v0y;
                        v1y_r   <= v1y;
                        v2y_r   <= v2y;
                        busy_r  <= 1'b1;
                        state_r <= ST_BOX;
                    end
                end
                ST_BOX: begin
                    if (empty_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        xmin_r      <= bx_min_s;
                        xmax_r      <= bx_max_s;
                        ymin_r      <= by_min_s;
                        ymax_r      <= by_max_s;
                        pix_x_r     <= bx_min_s;
                        pix_y_r     <= by_min_s;
                        pix_last_r  <= single_s;
                        pix_valid_r <= 1'b1;
                        state_r     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // pix_valid is always high here, so pix_ready alone means a transfer.
                    if (pix_ready) begin
                        if (pix_last_r) begin
                            pix_valid_r <= 1'b0;
                            pix_last_r  <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            pix_x_r    <= nx_s;
                            pix_y_r    <= ny_s;
                            pix_last_r <= (nx_s == xmax_r) && (ny_s == ymax_r);
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    pix_valid_r <= 1'b0;
                    pix_last_r  <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign tri_ready = (state_r == ST_IDLE);
    assign pix_valid = pix_valid_r;
    assign pix_x     = pix_x_r;
    assign pix_y     = pix_y_r;
    assign pix_last  = pix_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Testbench for raster_scan_ctrl: directed cases plus randomized triangles,
// each checked against a bounding-box model that enumerates expected pixels.
module tb_raster_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        tri_valid;
    logic        tri_ready;
    logic [15:0] v0x, v1x, v2x, v0y, v1y, v2y;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x, pix_y;
    logic        pix_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    raster_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .v0x       (v0x),
        .v1x       (v1x),
        .v2x       (v2x),
        .v0y       (v0y),
        .v1y       (v1y),
        .v2y       (v2y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Fixed point 10.6 to nearest integer, halves rounding up.
    function automatic int to_pix(input int v);
        return (v / 64) + ((v % 64) >= 32 ? 1 : 0);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles at (sx,sy)
    // abort_at >= 0: assert reset while pixel number abort_at is presented
    task automatic run_tri(input int ax0, input int ax1, input int ax2,
                           input int ay0, input int ay1, input int ay2,
                           input int mode, input int sx, input int sy,
                           input int abort_at);
        int qx[$];
        int qy[$];
        int xmn, xmx, ymn, ymx, guard, stalls, n_pop, stall_done;
        bit rdy;
        xmn = to_pix(imin(ax0, imin(ax1, ax2)));
        xmx = imin(to_pix(imax(ax0, imax(ax1, ax2))), 159);
        ymn = to_pix(imin(ay0, imin(ay1, ay2)));
        ymx = imin(to_pix(imax(ay0, imax(ay1, ay2))), 119);
        if (xmn <= 159 && ymn <= 119) begin
            for (int y = ymn; y <= ymx; y++) begin
                for (int x = xmn; x <= xmx; x++) begin
                    qx.push_back(x);
                    qy.push_back(y);
                end
            end
        end

        @(negedge clk);
        check_val("idle_tri_ready", int'(tri_ready), 1);
        check_val("idle_busy", int'(busy), 0);
        tri_valid = 1'b1;
        v0x = 16'(ax0); v1x = 16'(ax1); v2x = 16'(ax2);
        v0y = 16'(ay0); v1y = 16'(ay1); v2y = 16'(ay2);
        pix_ready = 1'b0;
        @(negedge clk);
        // BOX cycle; vertex inputs now scrambled and must be ignored
        tri_valid = 1'b0;
        v0x = 16'($urandom); v1x = 16'($urandom); v2x = 16'($urandom);
        v0y = 16'($urandom); v1y = 16'($urandom); v2y = 16'($urandom);
        check_val("box_tri_ready", int'(tri_ready), 0);
        check_val("box_busy", int'(busy), 1);
        check_val("box_pix_valid", int'(pix_valid), 0);

        guard = 0; stalls = 0; n_pop = 0; stall_done = 0;
        while (qx.size() > 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (abort_at >= 0 && n_pop == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_pix_valid", int'(pix_valid), 0);
                check_val("rst_busy", int'(busy), 0);
                check_val("rst_tri_ready", int'(tri_ready), 1);
                pix_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check_val("rst_done", int'(done), 0);
                end
                rst_n = 1'b1;
                return;
            end
            check_val("scan_pix_valid", int'(pix_valid), 1);
            check_val("scan_pix_x", int'(pix_x), qx[0]);
            check_val("scan_pix_y", int'(pix_y), qy[0]);
            check_val("scan_pix_last", int'(pix_last), (qx.size() == 1) ? 1 : 0);
            check_val("scan_done", int'(done), 0);
            check_val("scan_tri_ready", int'(tri_ready), 0);
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (mode == 1) begin
                rdy = ($urandom_range(0, 2) != 0) || (stalls >= 4);
            end else begin
                rdy = !(qx[0] == sx && qy[0] == sy && stall_done < 3);
                if (!rdy) stall_done++;
            end
            pix_ready = rdy;
            if (rdy) begin
                stalls = 0;
                n_pop++;
                void'(qx.pop_front());
                void'(qy.pop_front());
            end else begin
                stalls++;
            end
        end
        if (guard >= 5000) check_val("scan_timeout", 0, 1);
        if (mode == 2) check_val("stall_cycles", stall_done, 3);

        @(negedge clk);
        pix_ready = 1'b0;
        check_val("fin_done", int'(done), 1);
        check_val("fin_pix_valid", int'(pix_valid), 0);
        check_val("fin_tri_ready", int'(tri_ready), 0);
        @(negedge clk);
        check_val("post_done", int'(done), 0);
        check_val("post_tri_ready", int'(tri_ready), 1);
        check_val("post_busy", int'(busy), 0);
    endtask

    initial begin
        int bx, by;
        clk = 1'b0;
        rst_n = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b0;
        v0x = 16'h0000; v1x = 16'h0000; v2x = 16'h0000;
        v0y = 16'h0000; v1y = 16'h0000; v2y = 16'h0000;
        #12;
        check_val("reset_tri_ready", int'(tri_ready), 1);
        check_val("reset_pix_valid", int'(pix_valid), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_done", int'(done), 0);
        check_val("reset_pix_x", int'(pix_x), 0);
        check_val("reset_pix_y", int'(pix_y), 0);
        check_val("reset_pix_last", int'(pix_last), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic 3x3 box
        run_tri(16'h0080, 16'h0100, 16'h00C0, 16'h00C0, 16'h00C0, 16'h0140, 0, 0, 0, -1);
        // rounding: 2.5 -> 3, max 0xFFFF -> 1024 clamped to 159
        run_tri(16'h00A0, 16'h00A0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, -1);
        // rounding: 0x009F -> 2
        run_tri(16'h009F, 16'h00C0, 16'h00C0, 16'h0040, 16'h0040, 16'h0040, 0, 0, 0, -1);
        // backpressure at (3,4)
        run_tri(16'h0080, 16'h0100, 16'h00C0, 16'h00C0, 16'h00C0, 16'h0140, 2, 3, 4, -1);
        // fully off screen in x
        run_tri(16'h2800, 16'h3000, 16'hFFFF, 16'h0000, 16'h0100, 16'h0080, 0, 0, 0, -1);
        // off screen in y
        run_tri(16'h0000, 16'h0040, 16'h0080, 16'h1E00, 16'h1E40, 16'h2000, 0, 0, 0, -1);
        // clamp: 158.0 .. 200.0 gives columns 158,159
        run_tri(16'h2780, 16'h3200, 16'h2900, 16'h0040, 16'h0080, 16'h0040, 1, 0, 0, -1);
        // single point
        run_tri(16'h01C0, 16'h01C0, 16'h01C0, 16'h0240, 16'h0240, 16'h0240, 1, 0, 0, -1);
        // reset during pixel 5 of the basic case, then the same triangle again
        run_tri(16'h0080, 16'h0100, 16'h00C0, 16'h00C0, 16'h00C0, 16'h0140, 0, 0, 0, 4);
        run_tri(16'h0080, 16'h0100, 16'h00C0, 16'h00C0, 16'h00C0, 16'h0140, 0, 0, 0, -1);

        // randomized small triangles, some straddling or beyond screen edges
        for (int t = 0; t < 24; t++) begin
            bx = $urandom_range(0, 170 * 64);
            by = $urandom_range(0, 128 * 64);
            run_tri(bx + $urandom_range(0, 640), bx + $urandom_range(0, 640),
                    bx + $urandom_range(0, 640), by + $urandom_range(0, 640),
                    by + $urandom_range(0, 640), by + $urandom_range(0, 640),
                    1, 0, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
